lc3_writeback: RTL and testbench

Writeback stage directly upstream of the LC-3 register file. It merges results from the ALU path and the memory (load) path into a single registered `wr`/`dr`/`din` write port that drives the register file. It maintains the NZP condition-code register. It also keeps an 8-bit busy scoreboard so decode can detect pending writes to R0–R7.

---
 rtl/lc3_pkg.sv | 37 +++
 rtl/lc3_writeback_if.sv | 37 +++
 rtl/wb_skid_buf.sv | 33 +++
 rtl/lc3_writeback.sv | 100 ++++++++++
 tb/tb_lc3_writeback.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared types and helpers for the LC-3 writeback slice: widths, condition codes
// and the result-entry record carried from the ALU/load paths to the register file.
package lc3_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int NREG   = 2 ** REG_AW;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t NZP_RESET = nzp_t'(3'b010);

  typedef struct packed {
    logic [REG_AW-1:0] dr;
    logic [DATA_W-1:0] data;
    logic              setcc;
  } wb_entry_t;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

  function automatic nzp_t nzp_of(input logic [DATA_W-1:0] data);
    logic signed [DATA_W-1:0] sdata;
    nzp_t                     r;
    sdata = data;
    r     = '0;
    if (sdata < 0)       r.n = 1'b1;
    else if (sdata == 0) r.z = 1'b1;
    else                 r.p = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/lc3_writeback_if.sv
// Result/issue handshakes into the writeback stage and its register-file write port.
interface lc3_writeback_if;
  import lc3_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_dr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_setcc;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_dr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_setcc;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_dr;
  logic              wr;
  logic [REG_AW-1:0] dr;
  logic [DATA_W-1:0] din;
  nzp_t              nzp;
  logic [NREG-1:0]   busy;
  logic              err;

  modport master (
    output alu_valid, alu_dr, alu_data, alu_setcc,
    output mem_valid, mem_dr, mem_data, mem_setcc,
    output issue_valid, issue_dr,
    input  alu_ready, mem_ready, wr, dr, din, nzp, busy, err
  );

  modport slave (
    input  alu_valid, alu_dr, alu_data, alu_setcc,
    input  mem_valid, mem_dr, mem_data, mem_setcc,
    input  issue_valid, issue_dr,
    output alu_ready, mem_ready, wr, dr, din, nzp, busy, err
  );
endinterface

// File: rtl/wb_skid_buf.sv
// Single-entry skid holding the ALU result displaced by a same-cycle load;
// it always drains on the cycle after capture.
module wb_skid_buf
  import lc3_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      cap,
  input  wb_entry_t cap_entry,
  output logic      full,
  output wb_entry_t entry
);
  skid_state_t state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: if (cap) state <= SKID_FULL;
        SKID_FULL:  state <= SKID_EMPTY;
        default:    state <= SKID_EMPTY;
      endcase
    end
  end

  // Payload is not reset: it is only ever read while state is FULL.
  always_ff @(posedge clock) begin
    if (cap && state == SKID_EMPTY) entry <= cap_entry;
  end

  assign full = (state == SKID_FULL);
endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback: merges ALU and load results into one registered register-file
// write port, maintains NZP, and tracks pending destinations in a busy scoreboard.
module lc3_writeback
  import lc3_pkg::*;
(
  input logic           clock,
  input logic           reset,
  lc3_writeback_if.slave wb
);
  logic      skid_full;
  wb_entry_t skid_e;
  wb_entry_t alu_e;
  wb_entry_t mem_e;
  wb_entry_t sel_p0;
  logic      vld_p0;
  logic      ready_p0;
  logic      alu_acc;
  logic      mem_acc;

  logic              wr_p1;
  logic [REG_AW-1:0] dr_p1;
  logic [DATA_W-1:0] din_p1;
  nzp_t              nzp_q;
  logic [NREG-1:0]   busy_q;
  logic              err_q;

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            issue_err;
  logic            acc_err;

  assign ready_p0     = ~reset & ~skid_full;
  assign wb.alu_ready = ready_p0;
  assign wb.mem_ready = ready_p0;
  assign alu_acc      = wb.alu_valid & ready_p0;
  assign mem_acc      = wb.mem_valid & ready_p0;

  assign alu_e = '{dr: wb.alu_dr, data: wb.alu_data, setcc: wb.alu_setcc};
  assign mem_e = '{dr: wb.mem_dr, data: wb.mem_data, setcc: wb.mem_setcc};

  wb_skid_buf u_skid (
    .clock     (clock),
    .reset     (reset),
    .cap       (alu_acc & mem_acc),
    .cap_entry (alu_e),
    .full      (skid_full),
    .entry     (skid_e)
  );

  // Stage p0: fixed-priority select skid > load > ALU
  always_comb begin
    vld_p0 = 1'b0;
    sel_p0 = skid_e;
    if (skid_full) begin
      vld_p0 = 1'b1;
    end else if (mem_acc) begin
      vld_p0 = 1'b1;
      sel_p0 = mem_e;
    end else if (alu_acc) begin
      vld_p0 = 1'b1;
      sel_p0 = alu_e;
    end
  end

  always_comb begin
    set_mask  = wb.issue_valid ? (NREG'(1) << wb.issue_dr) : '0;
    clr_mask  = wr_p1 ? (NREG'(1) << dr_p1) : '0;
    issue_err = wb.issue_valid & busy_q[wb.issue_dr] & ~clr_mask[wb.issue_dr];
    acc_err   = (alu_acc & ~busy_q[wb.alu_dr]) | (mem_acc & ~busy_q[wb.mem_dr]);
  end

  // Stage p1: register-file write port, condition codes and scoreboard
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_p1  <= 1'b0;
      dr_p1  <= '0;
      din_p1 <= '0;
      nzp_q  <= NZP_RESET;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_p1 <= vld_p0;
      if (vld_p0) begin
        dr_p1  <= sel_p0.dr;
        din_p1 <= sel_p0.data;
        if (sel_p0.setcc) nzp_q <= nzp_of(sel_p0.data);
      end
      // Set is applied after clear so a same-cycle re-issue keeps the bit.
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      if (issue_err | acc_err) err_q <= 1'b1;
    end
  end

  assign wb.wr   = wr_p1;
  assign wb.dr   = dr_p1;
  assign wb.din  = din_p1;
  assign wb.nzp  = nzp_q;
  assign wb.busy = busy_q;
  assign wb.err  = err_q;
endmodule

// File: tb/tb_lc3_writeback.sv
// Directed and random checks of lc3_writeback against a queue-based result model.
module tb_lc3_writeback;
  import lc3_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lc3_writeback_if ifc ();

  lc3_writeback dut (
    .clock (clock),
    .reset (reset),
    .wb    (ifc.slave)
  );

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
    logic        setcc;
  } res_t;

  int errors = 0;
  int checks = 0;

  // Reference model: results waiting for the write port, in arrival order.
  res_t        pend[$];
  logic        m_wr;
  logic [2:0]  m_dr;
  logic [15:0] m_din;
  logic [2:0]  m_nzp;
  logic [7:0]  m_busy;
  logic        m_err;

  function automatic logic [2:0] ref_nzp(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic m_ready();
    return !reset && pend.size() == 0;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_wr = 0; m_dr = 0; m_din = 0; m_nzp = 3'b010; m_busy = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic acc_m, acc_a;
    logic [7:0] nb;
    res_t e;
    acc_m = ifc.mem_valid && m_ready();
    acc_a = ifc.alu_valid && m_ready();
    if (ifc.issue_valid && m_busy[ifc.issue_dr] && !(m_wr && m_dr == ifc.issue_dr)) m_err = 1;
    if (acc_m && !m_busy[ifc.mem_dr]) m_err = 1;
    if (acc_a && !m_busy[ifc.alu_dr]) m_err = 1;
    nb = m_busy;
    if (m_wr) nb[m_dr] = 1'b0;
    if (ifc.issue_valid) nb[ifc.issue_dr] = 1'b1;
    m_busy = nb;
    if (acc_m) pend.push_back('{ifc.mem_dr, ifc.mem_data, ifc.mem_setcc});
    if (acc_a) pend.push_back('{ifc.alu_dr, ifc.alu_data, ifc.alu_setcc});
    if (pend.size() > 0) begin
      e = pend.pop_front();
      m_wr = 1; m_dr = e.dr; m_din = e.data;
      if (e.setcc) m_nzp = ref_nzp(e.data);
    end else begin
      m_wr = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ".wr"},   32'(ifc.wr),   32'(m_wr));
    chk({ctx, ".dr"},   32'(ifc.dr),   32'(m_dr));
    chk({ctx, ".din"},  32'(ifc.din),  32'(m_din));
    chk({ctx, ".nzp"},  32'(ifc.nzp),  32'(m_nzp));
    chk({ctx, ".busy"}, 32'(ifc.busy), 32'(m_busy));
    chk({ctx, ".err"},  32'(ifc.err),  32'(m_err));
    chk({ctx, ".aready"}, 32'(ifc.alu_ready), 32'(m_ready()));
    chk({ctx, ".mready"}, 32'(ifc.mem_ready), 32'(m_ready()));
  endtask

  task automatic tick(input string ctx);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(ctx);
  endtask

  task automatic idle();
    ifc.alu_valid = 0; ifc.mem_valid = 0; ifc.issue_valid = 0;
  endtask

  task automatic issue(input logic [2:0] r);
    idle();
    ifc.issue_valid = 1; ifc.issue_dr = r;
    tick("issue");
    ifc.issue_valid = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #1 model_reset();
    compare_all("rst");
    @(posedge clock);
    #1 reset = 0;
  endtask

  logic [2:0]  got_dr[$];
  logic [15:0] got_din[$];
  int          k;
  logic        rdy;

  initial begin
    ifc.alu_valid = 0; ifc.alu_dr = 0; ifc.alu_data = 0; ifc.alu_setcc = 0;
    ifc.mem_valid = 0; ifc.mem_dr = 0; ifc.mem_data = 0; ifc.mem_setcc = 0;
    ifc.issue_valid = 0; ifc.issue_dr = 0;
    model_reset();

    // Power-on reset
    @(posedge clock); @(posedge clock); #1;
    chk("por.wr", 32'(ifc.wr), 32'd0);
    chk("por.nzp", 32'(ifc.nzp), 32'h2);
    chk("por.busy", 32'(ifc.busy), 32'd0);
    chk("por.ready", 32'(ifc.alu_ready), 32'd0);
    compare_all("por");
    reset = 0;

    // ALU only
    issue(3'd3);
    ifc.alu_valid = 1; ifc.alu_dr = 3; ifc.alu_data = 16'h8001; ifc.alu_setcc = 1;
    tick("alu_n");
    idle();
    chk("alu.wr", 32'(ifc.wr), 32'd1);
    chk("alu.dr", 32'(ifc.dr), 32'd3);
    chk("alu.din", 32'(ifc.din), 32'h8001);
    chk("alu.nzp", 32'(ifc.nzp), 32'h4);
    chk("alu.busy_n1", 32'(ifc.busy[3]), 32'd1);
    tick("alu_n1");
    chk("alu.busy_n2", 32'(ifc.busy[3]), 32'd0);

    // Load with setcc=0
    issue(3'd5);
    ifc.mem_valid = 1; ifc.mem_dr = 5; ifc.mem_data = 16'hFFFF; ifc.mem_setcc = 0;
    tick("ld");
    idle();
    chk("nosetcc.din", 32'(ifc.din), 32'hFFFF);
    chk("nosetcc.nzp", 32'(ifc.nzp), 32'h4);
    tick("ld1");

    // Collision
    issue(3'd1);
    issue(3'd2);
    ifc.alu_valid = 1; ifc.alu_dr = 1; ifc.alu_data = 16'h0000; ifc.alu_setcc = 1;
    ifc.mem_valid = 1; ifc.mem_dr = 2; ifc.mem_data = 16'h0005; ifc.mem_setcc = 1;
    tick("col_n");
    idle();
    chk("col.dr1", 32'(ifc.dr), 32'd2);
    chk("col.din1", 32'(ifc.din), 32'h5);
    chk("col.nzp1", 32'(ifc.nzp), 32'h1);
    chk("col.ready1", 32'(ifc.mem_ready), 32'd0);
    tick("col_n1");
    chk("col.wr2", 32'(ifc.wr), 32'd1);
    chk("col.dr2", 32'(ifc.dr), 32'd1);
    chk("col.din2", 32'(ifc.din), 32'h0);
    chk("col.nzp2", 32'(ifc.nzp), 32'h2);
    chk("col.ready2", 32'(ifc.alu_ready), 32'd1);
    tick("col_n2");

    // Scoreboard race
    issue(3'd4);
    ifc.alu_valid = 1; ifc.alu_dr = 4; ifc.alu_data = 16'h0007; ifc.alu_setcc = 0;
    tick("race_n");
    idle();
    ifc.issue_valid = 1; ifc.issue_dr = 4;
    tick("race_set");
    chk("race.busy4", 32'(ifc.busy[4]), 32'd1);
    chk("race.err0", 32'(ifc.err), 32'd0);
    tick("race_dup");
    idle();
    chk("race.err1", 32'(ifc.err), 32'd1);
    tick("race_sticky");
    chk("race.sticky", 32'(ifc.err), 32'd1);

    // Reset mid-stream with the skid holding a result
    do_reset();
    issue(3'd2);
    issue(3'd3);
    ifc.alu_valid = 1; ifc.alu_dr = 3; ifc.alu_data = 16'h1234; ifc.alu_setcc = 1;
    ifc.mem_valid = 1; ifc.mem_dr = 2; ifc.mem_data = 16'h4321; ifc.mem_setcc = 1;
    tick("rs_n");
    idle();
    chk("rs.busy_pre", 32'(ifc.busy), 32'h0C);
    do_reset();
    chk("rs.wr", 32'(ifc.wr), 32'd0);
    chk("rs.nzp", 32'(ifc.nzp), 32'h2);
    chk("rs.busy", 32'(ifc.busy), 32'd0);
    chk("rs.err", 32'(ifc.err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick("rs_after");
      chk("rs.nowrite", 32'(ifc.wr), 32'd0);
    end

    // Streaming: both sources valid for 10 cycles
    for (int r = 0; r < 8; r++) issue(3'(r));
    k = 0;
    ifc.mem_valid = 1; ifc.alu_valid = 1; ifc.mem_setcc = 1; ifc.alu_setcc = 1;
    for (int c = 0; c < 10; c++) begin
      ifc.mem_dr = 3'((2 * k) % 8);     ifc.mem_data = 16'h1000 + 16'(k);
      ifc.alu_dr = 3'((2 * k + 1) % 8); ifc.alu_data = 16'h2000 + 16'(k);
      rdy = ifc.mem_ready;
      tick("stream");
      if (ifc.wr) begin
        got_dr.push_back(ifc.dr);
        got_din.push_back(ifc.din);
      end
      if (rdy) k++;
    end
    idle();
    chk("stream.count", 32'(got_din.size()), 32'd10);
    for (int i = 0; i < got_din.size() && i < 10; i++) begin
      chk("stream.dr", 32'(got_dr[i]), 32'(i % 8));
      chk("stream.din", 32'(got_din[i]),
          (i % 2 == 0) ? 32'h1000 + 32'(i / 2) : 32'h2000 + 32'(i / 2));
    end
    tick("stream_end");
    tick("stream_end2");

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 300; c++) begin
      ifc.alu_valid   = ($urandom_range(0, 2) != 0);
      ifc.mem_valid   = ($urandom_range(0, 2) != 0);
      ifc.issue_valid = ($urandom_range(0, 1) != 0);
      ifc.alu_dr      = 3'($urandom_range(0, 7));
      ifc.mem_dr      = 3'($urandom_range(0, 7));
      ifc.issue_dr    = 3'($urandom_range(0, 7));
      ifc.alu_setcc   = 1'($urandom_range(0, 1));
      ifc.mem_setcc   = 1'($urandom_range(0, 1));
      ifc.alu_data    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      ifc.mem_data    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if (c == 150) begin
        idle();
        do_reset();
      end else begin
        tick("rand");
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
